tb_mailbox_monitor: RTL and testbench
=====================================

Name: tb_mailbox_monitor

Overview:
- Passive snoop on the LSU AHB-Lite bus between core and LSU memory slave in the simulation top.
- Decodes writes to the mailbox address, buffers printable characters in a FIFO for the console sink, and raises sticky finished/failed flags.
- Runs a cycle watchdog.
- Replaces ad-hoc bench logic with a clocked, checkable block.

Parameters:
- MBOX_ADDR, 32'hD058_0000, mailbox byte address; compared on haddr[31:3] only.
- FIFO_DEPTH, 16, character FIFO entries; power of 2, ≥2.
- MAX_CYCLES, 32'h0000_0800, watchdog limit in clk cycles after reset release.

Ports:
- clk  in  1  core clock, shared with the LSU AHB slave.
- rst  in  1  asynchronous, active-high reset.
- haddr  in  32  LSU AHB address.
- htrans  in  2  LSU AHB transfer type.
- hwrite  in  1  LSU AHB write.
- hsize  in  3  LSU AHB size (captured, not checked).
- hwdata  in  64  LSU AHB write data.
- hready  in  1  LSU AHB ready (slave HREADYOUT).
- char_valid  out  1  FIFO head valid.
- char_data  out  8  FIFO head character.
- char_ready  in  1  console sink accepts head.
- finished  out  1  sticky; a 0xFF byte was written to the mailbox.
- failed  out  1  sticky; a 0x01 byte was written to the mailbox.
- timeout  out  1  sticky; watchdog expired.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- char_count  out  32  characters accepted into the FIFO.
- cycle_count  out  32  cycles since reset release.

Behaviour:
- Reset (async, rst=1): all outputs 0; FIFO empty; pointers 0; address-phase register cleared.
- Address phase: when hready=1 && htrans[1]=1 && hwrite=1 && haddr[31:3]==MBOX_ADDR[31:3]:
  - set pend=1 and latch lane=haddr[2].
  - Otherwise, when hready=1, clear pend.
- Data phase: the first cycle with hready=1 and pend=1 is the mailbox write event.
  - Byte b = lane ? hwdata[39:32] : hwdata[7:0].
  - Wait states (hready=0) hold pend and lane.
  - Back-to-back mailbox writes produce one event per cycle.
- Decode of b on an event:
  - 8'hFF: finished <= 1; no FIFO push.
  - 8'h01: failed <= 1; no FIFO push.
  - 8'h06..8'h7E: push to the FIFO.
  - All other values: ignored.
- FIFO:
  - char_valid = !empty; char_data = mem[rd_ptr].
  - Pop when char_valid && char_ready.
  - Push and pop in the same cycle are both allowed, including when full (pop frees the slot; push accepted).
  - Push when full without a pop: the byte is dropped, overflow <= 1, char_count unchanged.
  - char_count increments on every accepted push and wraps at 2^32.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare.
  - First-write latency: b is visible on char_data with char_valid=1 one cycle after the data-phase event.
- Watchdog:
  - cycle_count increments every cycle while finished=0 && failed=0 && timeout=0, then freezes.
  - timeout <= 1 in the cycle cycle_count reaches MAX_CYCLES; it saturates there.
- Flags are independent and sticky until rst.
- After finished, the FIFO keeps draining; characters still arriving are still pushed.
- rst asserted mid-transfer: pend is cleared, so no event fires for a data phase that completes after reset release.

Test Plan:
- Write 0x48 to 0xD0580000 (lane 0), char_ready=1 -> char_valid high for exactly 1 cycle with char_data=0x48, one cycle after the data phase; char_count=1.
- Write 0x0000_0041_0000_0000 to 0xD0580004 with 2 wait states -> a single push of 0x41 after hready returns; no push during the wait states.
- char_ready=0, 17 back-to-back writes of 0x61 with FIFO_DEPTH=16 -> 16 entries stored, overflow=1, char_count=16. Then drain -> 16×0x61 out, then char_valid=0.
- Write 0xFF -> finished=1 next cycle, no push, cycle_count frozen. A following write of 0x01 -> failed=1, finished stays 1.
- Non-mailbox writes: write to 0xD0580008, read of 0xD0580000, htrans=IDLE with mailbox address, write of 0x05 -> no push, no flags.
- No mailbox activity -> timeout=1 at cycle_count=0x800 and held there. Assert rst mid-data-phase of a mailbox write -> all outputs 0 and no push after release.

Source files
------------

// File: rtl/tb_mailbox_monitor.sv
// Purpose : passive AHB-Lite snoop of the LSU bus; decodes mailbox writes into a
//           console character FIFO plus sticky finished/failed/timeout/overflow flags.
// Latency : a mailbox byte appears on char_data/char_valid one cycle after its data phase.
// Backpr. : char_ready stalls the FIFO head; a push into a full FIFO with no pop is dropped.
//
// Ports:
//   clk, rst                         core clock, asynchronous active-high reset
//   haddr/htrans/hwrite/hsize        LSU AHB address-phase signals (observed only)
//   hwdata, hready                   LSU AHB write data and slave ready (observed only)
//   char_valid/char_data/char_ready  console character stream (FIFO head)
//   finished, failed                 sticky: 0xFF / 0x01 byte written to the mailbox
//   timeout                          sticky: watchdog reached MAX_CYCLES
//   overflow                         sticky: a character was dropped on a full FIFO
//   char_count                       characters accepted into the FIFO (wraps)
//   cycle_count                      cycles since reset release, frozen once any end flag sets
module tb_mailbox_monitor #(
   parameter logic [31:0] MBOX_ADDR  = 32'hD058_0000,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] MAX_CYCLES = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [63:0] hwdata,
   input  logic        hready,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready,
   output logic        finished,
   output logic        failed,
   output logic        timeout,
   output logic        overflow,
   output logic [31:0] char_count,
   output logic [31:0] cycle_count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Address phase tracking
   // ------------------------------------------------------------------
   logic       pend;       // a mailbox write is in (or entering) its data phase
   logic       lane;       // haddr[2] of that write: selects the 32-bit half of hwdata
   logic [2:0] size_q;     // transfer size of that write, kept for debug visibility
   logic       addr_hit;

   // NONSEQ and SEQ both have htrans[1] set; IDLE/BUSY never start a transfer.
   assign addr_hit = htrans[1] && hwrite && (haddr[31:3] == MBOX_ADDR[31:3]);

   // The address phase is only sampled when hready is high; during wait states the
   // previous transfer is still in its data phase, so pend/lane must hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend   <= 1'b0;
         lane   <= 1'b0;
         size_q <= 3'd0;
      end else if (hready) begin
         pend <= addr_hit;
         if (addr_hit) begin
            lane   <= haddr[2];
            size_q <= hsize;
         end
      end
   end

   // ------------------------------------------------------------------
   // Data phase decode
   // ------------------------------------------------------------------
   logic       mbox_event;
   logic [7:0] wr_byte;
   logic       byte_fin;
   logic       byte_fail;
   logic       byte_char;

   assign mbox_event = pend && hready;
   assign wr_byte    = lane ? hwdata[39:32] : hwdata[7:0];
   assign byte_fin   = (wr_byte == 8'hFF);
   assign byte_fail  = (wr_byte == 8'h01);
   assign byte_char  = (wr_byte >= 8'h06) && (wr_byte <= 8'h7E);

   // ------------------------------------------------------------------
   // Character FIFO
   // ------------------------------------------------------------------
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        drop;

   // Extra MSB on the pointers separates "same slot, same lap" (empty) from
   // "same slot, one lap ahead" (full).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign pop      = !empty && char_ready;
   assign push_req = mbox_event && byte_char;
   // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   assign char_valid = !empty;
   // Gate the head with empty so stale storage never shows after reset or drain.
   assign char_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   // Storage has no reset: it is never observed while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_byte;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         char_count <= 32'd0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + {{AW{1'b0}}, 1'b1};
            char_count <= char_count + 32'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // End-of-test flags and watchdog
   // ------------------------------------------------------------------
   logic        wd_run;
   logic [31:0] cycle_next;

   // The counter stops on the first end condition so the final value records
   // how long the run took.
   assign wd_run     = !finished && !failed && !timeout;
   assign cycle_next = cycle_count + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         finished    <= 1'b0;
         failed      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= 32'd0;
      end else begin
         if (mbox_event && byte_fin) begin
            finished <= 1'b1;
         end
         if (mbox_event && byte_fail) begin
            failed <= 1'b1;
         end
         if (wd_run) begin
            cycle_count <= cycle_next;
            // timeout rises together with cycle_count reaching the limit.
            if (cycle_next == MAX_CYCLES) begin
               timeout <= 1'b1;
            end
         end
      end
   end

   // Bus bits this monitor deliberately ignores.
   logic unused_bits;
   assign unused_bits = ^{size_q, haddr[1:0], hwdata[63:40], hwdata[31:8]};

endmodule

// File: tb/tb_tb_mailbox_monitor.sv
module tb_tb_mailbox_monitor;

   localparam logic [31:0] MBOX  = 32'hD058_0000;
   localparam int          DEPTH = 16;
   localparam logic [31:0] MAXC  = 32'h0000_0800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] haddr = 32'd0;
   logic [1:0]  htrans = 2'd0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd0;
   logic [63:0] hwdata = 64'd0;
   logic        hready = 1'b1;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready = 1'b0;
   logic        finished;
   logic        failed;
   logic        timeout;
   logic        overflow;
   logic [31:0] char_count;
   logic [31:0] cycle_count;

   always #5 clk = ~clk;

   tb_mailbox_monitor #(
      .MBOX_ADDR (MBOX),
      .FIFO_DEPTH(DEPTH),
      .MAX_CYCLES(MAXC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .haddr      (haddr),
      .htrans     (htrans),
      .hwrite     (hwrite),
      .hsize      (hsize),
      .hwdata     (hwdata),
      .hready     (hready),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .finished   (finished),
      .failed     (failed),
      .timeout    (timeout),
      .overflow   (overflow),
      .char_count (char_count),
      .cycle_count(cycle_count)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- transaction description ----------------
   typedef enum int {K_IDLE, K_MB0, K_MB1, K_WR_OTHER, K_RD_MB, K_IDLE_MB} kind_t;
   typedef struct {
      kind_t       kind;
      logic [7:0]  b;
      int          waits;   // wait states in this transfer's data phase
      logic [63:0] d;
      logic        alt;     // SEQ instead of NONSEQ / BUSY instead of IDLE
   } xfer_t;

   xfer_t xq[$];

   function automatic xfer_t mk(input kind_t k, input logic [7:0] b, input int w);
      xfer_t x;
      logic [7:0] oth;
      x.kind  = k;
      x.b     = b;
      x.waits = w;
      x.d     = {$urandom, $urandom};
      x.alt   = 1'($urandom_range(0, 1));
      // Other lane carries a different printable byte so a lane mix-up shows.
      oth = (b == 8'h48) ? 8'h49 : 8'h48;
      case (k)
         K_MB0:   begin x.d[7:0] = b;   x.d[39:32] = oth; end
         K_MB1:   begin x.d[39:32] = b; x.d[7:0] = oth;   end
         default: begin x.d[7:0] = b;   x.d[39:32] = b;   end
      endcase
      return x;
   endfunction

   function automatic bit is_mbox_write(input xfer_t x);
      return (x.kind == K_MB0) || (x.kind == K_MB1);
   endfunction

   task automatic drive_addr(input xfer_t x);
      hsize = 3'd0;
      case (x.kind)
         K_MB0:      begin haddr = MBOX;         htrans = x.alt ? 2'b11 : 2'b10; hwrite = 1'b1; end
         K_MB1:      begin haddr = MBOX + 32'd4; htrans = x.alt ? 2'b11 : 2'b10; hwrite = 1'b1; end
         K_WR_OTHER: begin haddr = MBOX + 32'd8; htrans = 2'b10; hwrite = 1'b1; end
         K_RD_MB:    begin haddr = MBOX;         htrans = 2'b10; hwrite = 1'b0; end
         K_IDLE_MB:  begin haddr = MBOX;         htrans = x.alt ? 2'b01 : 2'b00; hwrite = 1'b1; end
         default:    begin haddr = 32'h0000_1000; htrans = 2'b00; hwrite = 1'b0; end
      endcase
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [7:0]  mq[$];
   bit          m_fin, m_fail, m_to, m_ovf;
   logic [31:0] m_cnt, m_cyc;
   bit          ev_vld = 1'b0;     // the bench's mailbox write completes at the coming edge
   logic [7:0]  ev_byte = 8'd0;
   bit          rand_rdy = 1'b0;
   int          tickn, last_ev_tick, first_valid_tick, valid_cycles, pops, pop61;

   task automatic model_reset();
      mq.delete();
      m_fin = 0; m_fail = 0; m_to = 0; m_ovf = 0;
      m_cnt = 32'd0; m_cyc = 32'd0;
      tickn = 0; last_ev_tick = -1; first_valid_tick = -1;
      valid_cycles = 0; pops = 0; pop61 = 0;
   endtask

   task automatic compare_all();
      chk("char_valid", 64'(char_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("char_data", 64'(char_data), 64'(mq[0]));
      chk("finished",    64'(finished),    64'(m_fin));
      chk("failed",      64'(failed),      64'(m_fail));
      chk("timeout",     64'(timeout),     64'(m_to));
      chk("overflow",    64'(overflow),    64'(m_ovf));
      chk("char_count",  64'(char_count),  64'(m_cnt));
      chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
   endtask

   // One clock: advance the model by the rules, clock the DUT, compare.
   task automatic tick();
      bit counting;
      if (rand_rdy) char_ready = ($urandom_range(0, 9) < 3);
      counting = !(m_fin || m_fail || m_to);
      if (char_ready && mq.size() != 0) void'(mq.pop_front());
      if (ev_vld) begin
         if (ev_byte == 8'hFF) m_fin = 1;
         else if (ev_byte == 8'h01) m_fail = 1;
         else if (ev_byte >= 8'h06 && ev_byte <= 8'h7E) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(ev_byte);
               m_cnt = m_cnt + 32'd1;
            end else begin
               m_ovf = 1;
            end
         end
      end
      if (counting) begin
         m_cyc = m_cyc + 32'd1;
         if (m_cyc == MAXC) m_to = 1;
      end
      if (char_valid && char_ready) begin
         pops++;
         if (char_data == 8'h61) pop61++;
      end
      @(posedge clk);
      #1;
      tickn++;
      if (ev_vld) last_ev_tick = tickn;
      if (char_valid) begin
         valid_cycles++;
         if (first_valid_tick < 0) first_valid_tick = tickn;
      end
      compare_all();
   endtask

   task automatic idle_ticks(input int n);
      xfer_t x;
      x = mk(K_IDLE, 8'h00, 0);
      drive_addr(x);
      hready = 1'b1;
      ev_vld = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Pipelined AHB driver: each transfer's address phase overlaps the previous one's data phase.
   task automatic run_xfers();
      xfer_t prev, cur;
      prev = mk(K_IDLE, 8'h00, 0);
      for (int i = 0; i <= xq.size(); i++) begin
         cur = (i < xq.size()) ? xq[i] : mk(K_IDLE, 8'h00, 0);
         drive_addr(cur);
         hwdata = prev.d;
         for (int w = 0; w < prev.waits; w++) begin
            hready = 1'b0;
            ev_vld = 1'b0;
            tick();
         end
         hready  = 1'b1;
         ev_vld  = is_mbox_write(prev);
         ev_byte = prev.b;
         tick();
         ev_vld = 1'b0;
         prev = cur;
      end
      xq.delete();
      drive_addr(mk(K_IDLE, 8'h00, 0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_addr(mk(K_IDLE, 8'h00, 0));
      hwdata = 64'd0;
      hready = 1'b1;
      char_ready = 1'b0;
      ev_vld = 1'b0;
      rand_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- decode vectors ----------------
   typedef struct {
      logic [7:0] b;
      logic       lane;
      logic       exp_push;
      logic       exp_fin;
      logic       exp_fail;
   } vec_t;

   vec_t vt[11];

   initial begin
      xfer_t x;
      vt[0]  = '{8'h48, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{8'h41, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{8'h06, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{8'h7E, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[8]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[9]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[10] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state
      do_reset();
      #1;
      chk("rst_char_valid",  64'(char_valid),  64'(0));
      chk("rst_char_data",   64'(char_data),   64'(0));
      chk("rst_finished",    64'(finished),    64'(0));
      chk("rst_failed",      64'(failed),      64'(0));
      chk("rst_timeout",     64'(timeout),     64'(0));
      chk("rst_overflow",    64'(overflow),    64'(0));
      chk("rst_char_count",  64'(char_count),  64'(0));
      chk("rst_cycle_count", 64'(cycle_count), 64'(0));

      // Single-write decode table
      for (int i = 0; i < 11; i++) begin
         do_reset();
         xq.push_back(mk(vt[i].lane ? K_MB1 : K_MB0, vt[i].b, 0));
         run_xfers();
         chk("vec_valid", 64'(char_valid), 64'(vt[i].exp_push));
         if (vt[i].exp_push) chk("vec_data", 64'(char_data), 64'(vt[i].b));
         chk("vec_fin",   64'(finished),   64'(vt[i].exp_fin));
         chk("vec_fail",  64'(failed),     64'(vt[i].exp_fail));
         chk("vec_count", 64'(char_count), 64'(vt[i].exp_push));
      end

      // First-write latency with the sink always ready
      do_reset();
      char_ready = 1'b1;
      xq.push_back(mk(K_MB0, 8'h48, 0));
      run_xfers();
      idle_ticks(3);
      chk("lat_first_valid_tick", 64'(first_valid_tick), 64'(last_ev_tick));
      chk("lat_valid_cycles",     64'(valid_cycles),     64'(1));
      chk("lat_char_count",       64'(char_count),       64'(1));

      // Upper lane with two wait states: exactly one push, after hready returns
      do_reset();
      xq.push_back(mk(K_MB1, 8'h41, 2));
      run_xfers();
      chk("ws_first_valid_tick", 64'(first_valid_tick), 64'(4));
      chk("ws_char_data",        64'(char_data),        64'(8'h41));
      chk("ws_char_count",       64'(char_count),       64'(1));

      // Overflow: 17 writes into a 16-entry FIFO, then drain
      do_reset();
      for (int i = 0; i < 17; i++) xq.push_back(mk(K_MB0, 8'h61, 0));
      run_xfers();
      chk("ovf_overflow",   64'(overflow),   64'(1));
      chk("ovf_char_count", 64'(char_count), 64'(16));
      char_ready = 1'b1;
      pops = 0;
      pop61 = 0;
      idle_ticks(20);
      chk("ovf_drain_pops", 64'(pops),       64'(16));
      chk("ovf_drain_61",   64'(pop61),      64'(16));
      chk("ovf_drained",    64'(char_valid), 64'(0));

      // finished freezes the watchdog; failed follows independently
      do_reset();
      char_ready = 1'b1;
      xq.push_back(mk(K_MB0, 8'hFF, 0));
      run_xfers();
      idle_ticks(5);
      chk("fin_finished",    64'(finished),    64'(1));
      chk("fin_no_push",     64'(char_count),  64'(0));
      chk("fin_cycle_count", 64'(cycle_count), 64'(2));
      xq.push_back(mk(K_MB1, 8'h01, 0));
      xq.push_back(mk(K_MB0, 8'h50, 0));
      run_xfers();
      chk("fail_failed",      64'(failed),      64'(1));
      chk("fail_finished",    64'(finished),    64'(1));
      chk("fail_cycle_count", 64'(cycle_count), 64'(2));
      chk("fin_still_pushes", 64'(char_count),  64'(1));

      // Traffic that must not reach the mailbox
      do_reset();
      xq.push_back(mk(K_WR_OTHER, 8'h48, 0));
      xq.push_back(mk(K_RD_MB,    8'h48, 1));
      xq.push_back(mk(K_IDLE_MB,  8'h48, 0));
      xq.push_back(mk(K_MB0,      8'h05, 0));
      run_xfers();
      idle_ticks(2);
      chk("nm_char_count", 64'(char_count), 64'(0));
      chk("nm_char_valid", 64'(char_valid), 64'(0));
      chk("nm_finished",   64'(finished),   64'(0));
      chk("nm_failed",     64'(failed),     64'(0));

      // Watchdog expiry and saturation
      do_reset();
      for (int i = 1; i <= 32'h80A; i++) begin
         tick();
         if (i == 32'h7FF) chk("wd_timeout_early", 64'(timeout), 64'(0));
         if (i == 32'h800) begin
            chk("wd_timeout_at", 64'(timeout), 64'(1));
            chk("wd_count_at",   64'(cycle_count), 64'(32'h800));
         end
      end
      chk("wd_count_held", 64'(cycle_count), 64'(32'h800));

      // Reset asserted during the data phase of a mailbox write
      do_reset();
      xq.push_back(mk(K_MB0, 8'h5A, 0));
      run_xfers();
      chk("rm_pre_valid", 64'(char_valid), 64'(1));
      x = mk(K_MB0, 8'h48, 0);
      drive_addr(x);
      hready = 1'b1;
      ev_vld = 1'b0;
      tick();
      drive_addr(mk(K_IDLE, 8'h00, 0));
      hwdata = x.d;
      hready = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rm_char_valid",  64'(char_valid),  64'(0));
      chk("rm_char_data",   64'(char_data),   64'(0));
      chk("rm_char_count",  64'(char_count),  64'(0));
      chk("rm_cycle_count", 64'(cycle_count), 64'(0));
      chk("rm_flags",       64'({finished, failed, timeout, overflow}), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      hready = 1'b1;
      tick();
      idle_ticks(2);
      chk("rm_no_push_valid", 64'(char_valid), 64'(0));
      chk("rm_no_push_count", 64'(char_count), 64'(0));

      // Randomized traffic against the model
      do_reset();
      rand_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         int r, p;
         logic [7:0] b;
         kind_t k;
         r = $urandom_range(0, 9);
         p = $urandom_range(0, 99);
         if (p < 90)      b = 8'($urandom_range(6, 126));
         else if (p < 95) b = 8'($urandom_range(0, 255));
         else if (p < 98) b = 8'hFF;
         else             b = 8'h01;
         case (r)
            0, 1, 2: k = K_MB0;
            3, 4, 5: k = K_MB1;
            6:       k = K_WR_OTHER;
            7:       k = K_RD_MB;
            8:       k = K_IDLE_MB;
            default: k = K_IDLE;
         endcase
         xq.push_back(mk(k, b, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2))));
      end
      run_xfers();
      idle_ticks(30);
      rand_rdy = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
